// File: rtl/display_multiplexor.sv
// Time-multiplexed scan of N_DIGITOS common-anode 7-segment digits through one shared decoder.
// Each digit gets a blanking interval then a lit interval; digits are snapshotted once per frame.
module display_multiplexor #(
  parameter int N_DIGITOS      = 6,
  parameter int CICLOS_ON      = 1000,
  parameter int CICLOS_APAGADO = 50
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   habilitar,
  input  logic [4*N_DIGITOS-1:0] digitos_in,
  input  logic [N_DIGITOS-1:0]   puntos_in,
  output logic [3:0]             digito,
  output logic [N_DIGITOS-1:0]   anodos,
  output logic                   punto,
  output logic                   fin_barrido,
  output logic [1:0]             estado_dbg
);

  localparam int MAXC = (CICLOS_ON > CICLOS_APAGADO) ? CICLOS_ON : CICLOS_APAGADO;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;

  typedef enum logic [1:0] {
    INACTIVO  = 2'd0,
    APAGADO   = 2'd1,
    ENCENDIDO = 2'd2
  } estado_t;

  estado_t                estado, estado_sig;
  logic [IW-1:0]          indice, indice_sig;
  logic [CW-1:0]          cnt, cnt_sig;
  logic [4*N_DIGITOS-1:0] snap_d, snap_d_sig;
  logic [N_DIGITOS-1:0]   snap_p, snap_p_sig;
  logic [3:0]             digito_sig;
  logic [N_DIGITOS-1:0]   anodos_sig;
  logic                   punto_sig;
  logic                   fin_sig;

  assign estado_dbg = estado;

  always_comb begin
    estado_sig = estado;
    indice_sig = indice;
    cnt_sig    = cnt;
    snap_d_sig = snap_d;
    snap_p_sig = snap_p;
    fin_sig    = 1'b0;

    // Dropping the enable wins over every other transition, including end of frame.
    if (!habilitar) begin
      estado_sig = INACTIVO;
      indice_sig = '0;
      cnt_sig    = '0;
    end else begin
      case (estado)
        INACTIVO: begin
          estado_sig = APAGADO;
          indice_sig = '0;
          cnt_sig    = '0;
          snap_d_sig = digitos_in;
          snap_p_sig = puntos_in;
        end
        APAGADO: begin
          if (cnt == CW'(CICLOS_APAGADO - 1)) begin
            estado_sig = ENCENDIDO;
            cnt_sig    = '0;
          end else begin
            cnt_sig = cnt + CW'(1);
          end
        end
        ENCENDIDO: begin
          if (cnt == CW'(CICLOS_ON - 1)) begin
            estado_sig = APAGADO;
            cnt_sig    = '0;
            if (indice == IW'(N_DIGITOS - 1)) begin
              indice_sig = '0;
              snap_d_sig = digitos_in;
              snap_p_sig = puntos_in;
              fin_sig    = 1'b1;
            end else begin
              indice_sig = indice + IW'(1);
            end
          end else begin
            cnt_sig = cnt + CW'(1);
          end
        end
        default: begin
          estado_sig = INACTIVO;
          indice_sig = '0;
          cnt_sig    = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    anodos_sig = '1;
    digito_sig = 4'd0;
    punto_sig  = 1'b0;
    case (estado_sig)
      APAGADO: begin
        digito_sig = snap_d_sig[{indice_sig, 2'b00} +: 4];
      end
      ENCENDIDO: begin
        anodos_sig[indice_sig] = 1'b0;
        digito_sig             = snap_d_sig[{indice_sig, 2'b00} +: 4];
        punto_sig              = snap_p_sig[indice_sig];
      end
      default: begin
        anodos_sig = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= INACTIVO;
      indice      <= '0;
      cnt         <= '0;
      snap_d      <= '0;
      snap_p      <= '0;
      anodos      <= '1;
      digito      <= 4'd0;
      punto       <= 1'b0;
      fin_barrido <= 1'b0;
    end else begin
      estado      <= estado_sig;
      indice      <= indice_sig;
      cnt         <= cnt_sig;
      snap_d      <= snap_d_sig;
      snap_p      <= snap_p_sig;
      anodos      <= anodos_sig;
      digito      <= digito_sig;
      punto       <= punto_sig;
      fin_barrido <= fin_sig;
    end
  end

endmodule

// File: tb/tb_display_multiplexor.sv
// Bench for display_multiplexor: frame-position reference model with a per-cycle expected queue,
// a literal table for one full frame, and hand sequences for snapshot, disable and async reset.
module tb_display_multiplexor;

  localparam int N     = 6;
  localparam int CO    = 4;
  localparam int CA    = 2;
  localparam int PER   = CO + CA;
  localparam int FRAME = N * PER;

  logic           clk;
  logic           rst_n;
  logic           habilitar;
  logic [4*N-1:0] digitos_in;
  logic [N-1:0]   puntos_in;
  logic [3:0]     digito;
  logic [N-1:0]   anodos;
  logic           punto;
  logic           fin_barrido;
  logic [1:0]     estado_dbg;

  int tests = 0;
  int fails = 0;

  display_multiplexor #(
    .N_DIGITOS(N),
    .CICLOS_ON(CO),
    .CICLOS_APAGADO(CA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .habilitar(habilitar),
    .digitos_in(digitos_in),
    .puntos_in(puntos_in),
    .digito(digito),
    .anodos(anodos),
    .punto(punto),
    .fin_barrido(fin_barrido),
    .estado_dbg(estado_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nombre, input logic [31:0] real_v, input logic [31:0] req);
    tests++;
    if (real_v !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", nombre, real_v, req, $time);
    end
  endtask

  // reference model: position inside the frame since the scan was enabled
  logic           m_act;
  int             m_t;
  logic [4*N-1:0] m_sd;
  logic [N-1:0]   m_sp;
  logic           m_dig0;
  logic [12:0]    exp_q[$];   // {digito_known, fin, punto, digito, anodos}

  function automatic logic [12:0] model_salida();
    int         pos;
    int         d;
    logic       lit;
    logic [5:0] an;
    logic [3:0] dg;
    logic       pt;
    logic       fn;
    if (!m_act) return {m_dig0, 1'b0, 1'b0, 4'd0, 6'h3F};
    pos = m_t % FRAME;
    d   = pos / PER;
    lit = (pos % PER) >= CA;
    an  = lit ? ~(6'd1 << d) : 6'h3F;
    dg  = m_sd[4*d +: 4];
    pt  = lit & m_sp[d];
    fn  = (m_t > 0) && (pos == 0);
    return {1'b1, fn, pt, dg, an};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act  = 1'b0;
      m_t    = 0;
      m_sd   = '0;
      m_sp   = '0;
      m_dig0 = 1'b1;
      exp_q.delete();
    end else begin
      if (!habilitar) begin
        m_act = 1'b0;
      end else if (!m_act) begin
        m_act  = 1'b1;
        m_t    = 0;
        m_sd   = digitos_in;
        m_sp   = puntos_in;
        m_dig0 = 1'b0;
      end else begin
        m_t++;
        if (m_t % FRAME == 0) begin
          m_sd = digitos_in;
          m_sp = puntos_in;
        end
      end
      exp_q.push_back(model_salida());
    end
  end

  // scoreboard: one expected record per cycle, compared on the falling edge
  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = {1'b1, 1'b0, 1'b0, 4'd0, 6'h3F};
    check("model_anodos", 32'(anodos), 32'(e[5:0]));
    check("model_punto", 32'(punto), 32'(e[10]));
    check("model_fin", 32'(fin_barrido), 32'(e[11]));
    if (e[12]) check("model_digito", 32'(digito), 32'(e[9:6]));
    check("one_anode_low", 32'($countones(~anodos) <= 1), 32'(1));
  end

  // driver tasks
  task automatic wait_lit(input int d);
    int         n;
    logic [5:0] objetivo;
    n        = 0;
    objetivo = ~(6'd1 << d);
    @(negedge clk);
    while (anodos !== objetivo && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("wait_lit_%0d", d), 32'(anodos), 32'(objetivo));
  endtask

  typedef struct packed {
    logic [5:0] an;
    logic [3:0] dg;
    logic       pt;
  } vec_t;

  vec_t tabla[N];
  int   fin_cnt;
  logic hab_r;

  initial begin
    tabla[0] = '{an: 6'b111110, dg: 4'd6, pt: 1'b0};
    tabla[1] = '{an: 6'b111101, dg: 4'd5, pt: 1'b0};
    tabla[2] = '{an: 6'b111011, dg: 4'd4, pt: 1'b1};
    tabla[3] = '{an: 6'b110111, dg: 4'd3, pt: 1'b0};
    tabla[4] = '{an: 6'b101111, dg: 4'd2, pt: 1'b1};
    tabla[5] = '{an: 6'b011111, dg: 4'd1, pt: 1'b0};

    rst_n      = 1'b1;
    habilitar  = 1'b0;
    digitos_in = '0;
    puntos_in  = '0;
    #1 rst_n = 1'b0;

    // reset and idle
    repeat (3) begin
      @(negedge clk);
      check("reset_anodos", 32'(anodos), 32'h3F);
      check("reset_digito", 32'(digito), 32'h0);
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      check("idle_anodos", 32'(anodos), 32'h3F);
      check("idle_digito", 32'(digito), 32'h0);
      check("idle_punto", 32'(punto), 32'h0);
      check("idle_fin", 32'(fin_barrido), 32'h0);
    end

    // full frame against the literal table
    digitos_in = 24'h123456;
    puntos_in  = 6'b010100;
    habilitar  = 1'b1;
    for (int i = 0; i < N; i++) begin
      for (int c = 0; c < PER; c++) begin
        @(negedge clk);
        if (c < CA) begin
          check($sformatf("frame_blank_an_%0d", i), 32'(anodos), 32'h3F);
          check($sformatf("frame_blank_pt_%0d", i), 32'(punto), 32'h0);
        end else begin
          check($sformatf("frame_lit_an_%0d", i), 32'(anodos), 32'(tabla[i].an));
          check($sformatf("frame_lit_pt_%0d", i), 32'(punto), 32'(tabla[i].pt));
        end
        check($sformatf("frame_dig_%0d", i), 32'(digito), 32'(tabla[i].dg));
        check("frame_fin_low", 32'(fin_barrido), 32'h0);
      end
    end
    @(negedge clk);
    check("frame_fin_pulse", 32'(fin_barrido), 32'h1);
    check("frame_fin_blank", 32'(anodos), 32'h3F);

    // snapshot integrity
    wait_lit(2);
    digitos_in = 24'h999999;
    wait_lit(4);
    check("snap_old_digit4", 32'(digito), 32'h2);
    wait_lit(0);
    check("snap_new_digit0", 32'(digito), 32'h9);
    wait_lit(5);
    check("snap_new_digit5", 32'(digito), 32'h9);

    // disable mid-digit, then re-enable
    wait_lit(3);
    habilitar = 1'b0;
    @(negedge clk);
    check("disable_anodos", 32'(anodos), 32'h3F);
    check("disable_punto", 32'(punto), 32'h0);
    repeat (3) @(negedge clk);
    digitos_in = 24'hABCDEF;
    puntos_in  = 6'b000001;
    habilitar  = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("reenable_blank", 32'(anodos), 32'h3F);
    end
    @(negedge clk);
    check("reenable_anodos", 32'(anodos), 32'h3E);
    check("reenable_digito_f", 32'(digito), 32'hF);
    check("reenable_punto", 32'(punto), 32'h1);

    // asynchronous reset while digit 5 is lit
    wait_lit(5);
    #2 rst_n = 1'b0;
    #1;
    check("async_anodos", 32'(anodos), 32'h3F);
    check("async_digito", 32'(digito), 32'h0);
    check("async_punto", 32'(punto), 32'h0);
    check("async_fin", 32'(fin_barrido), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("restart_blank", 32'(anodos), 32'h3F);
    end
    @(negedge clk);
    check("restart_anodos", 32'(anodos), 32'h3E);
    check("restart_digito", 32'(digito), 32'hF);

    // ten continuous frames
    habilitar = 1'b0;
    repeat (2) @(negedge clk);
    digitos_in = 24'($urandom);
    puntos_in  = 6'($urandom);
    habilitar  = 1'b1;
    fin_cnt    = 0;
    for (int k = 0; k <= 10 * FRAME; k++) begin
      @(negedge clk);
      if (fin_barrido) fin_cnt++;
    end
    check("ten_frames_fin_count", 32'(fin_cnt), 32'd10);

    // randomized traffic checked by the model
    hab_r = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (hab_r) begin
        if ($urandom_range(0, 199) == 0) hab_r = 1'b0;
      end else if ($urandom_range(0, 4) == 0) begin
        hab_r = 1'b1;
      end
      habilitar = hab_r;
      if ($urandom_range(0, 29) == 0) digitos_in = 24'($urandom);
      if ($urandom_range(0, 29) == 0) puntos_in = 6'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_multiplexor.md
# display_multiplexor

Time-multiplexed scan controller for the digital clock's six 7-segment displays. It shares the single `display7segmentos` decoder between all digit positions: it presents one BCD digit at a time on the decoder input and enables the matching common-anode line. A blanking interval is inserted between digits to suppress ghosting. Input digits are snapshotted once per frame, so a time update never tears a frame.

## Interface

Parameters:
- `N_DIGITOS`, 6: number of digit positions (HH:MM:SS).
- `CICLOS_ON`, 1000: clock cycles each digit is lit; must be ≥ 1.
- `CICLOS_APAGADO`, 50: clock cycles all anodes are off before each digit; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `habilitar`  in  1  scan enable; level-sensitive.
- `digitos_in`  in  4*N_DIGITOS  BCD digits; digit i is bits [4i+3:4i]; digit 0 is the rightmost position.
- `puntos_in`  in  N_DIGITOS  decimal-point/colon request per digit.
- `digito`  out  4  BCD value to the decoder's `digito` input.
- `anodos`  out  N_DIGITOS  digit enables, active-low, at most one low at any time.
- `punto`  out  1  decimal point for the lit digit, active-high.
- `fin_barrido`  out  1  one-cycle pulse at the end of each complete frame.

## Operation

- All outputs are registered. Internal state: FSM, digit index `indice`, cycle counter, snapshot registers.
- Reset (async, `rst_n`=0): FSM=INACTIVO, `indice`=0, counter=0, snapshot=0; `anodos`=all 1, `digito`=0, `punto`=0, `fin_barrido`=0.
- INACTIVO: `anodos` all 1, `punto`=0. When `habilitar`=1, capture `digitos_in`/`puntos_in` into the snapshot, set `indice`=0 and counter=0, and go to APAGADO.
- APAGADO: `anodos` all 1; `digito`=snapshot[indice], so the decoder input settles before the anode turns on; `punto`=0. After CICLOS_APAGADO cycles, go to ENCENDIDO with counter=0.
- ENCENDIDO: `anodos[indice]`=0 and all others 1; `digito`=snapshot[indice]; `punto`=snapshot_puntos[indice]. After CICLOS_ON cycles:
  - If `indice` < N_DIGITOS-1: `indice`++, go to APAGADO.
  - If `indice` = N_DIGITOS-1: pulse `fin_barrido`, set `indice`=0, re-capture the snapshot, and go to APAGADO.
- `habilitar`=0 in any state: the next edge goes to INACTIVO, with `anodos` all 1 and `indice`=0. This takes priority over every other transition, including the end-of-frame step.
- Digit values 10–15 pass through unchanged; the decoder defines their glyph.
- Changes on `digitos_in` mid-frame have no effect until the next snapshot.

## Timing

- Per digit: CICLOS_APAGADO blank cycles, then CICLOS_ON lit cycles.
- Frame period: N_DIGITOS*(CICLOS_APAGADO+CICLOS_ON) cycles.
- Start of scan: if `habilitar` is sampled 1 at edge E0 in INACTIVO, APAGADO outputs appear after E0. `anodos[0]` goes low after edge E0+CICLOS_APAGADO.
- Lit window: `anodos[i]` stays low for exactly CICLOS_ON cycles. It returns high on the same edge that starts the next APAGADO. There is never overlap between two low anodes, and no cycle has one anode low while `digito` is changing.
- `fin_barrido`: high for exactly one cycle, namely the first APAGADO cycle of the following frame. The new snapshot is valid in that same cycle.
- Disable: after `habilitar` is sampled 0, `anodos` are all 1 within 1 cycle. Re-enable starts a fresh frame at digit 0.
- Reset mid-frame: outputs take their reset values immediately, without waiting for a clock edge.

## Test plan

All scenarios use N_DIGITOS=6, CICLOS_ON=4, CICLOS_APAGADO=2.

- **Reset/idle:** hold `rst_n`=0, then release with `habilitar`=0 for 20 cycles. Required: `anodos`=6'b111111, `digito`=0, `punto`=0, `fin_barrido`=0 throughout.
- **Full frame:** `digitos_in`=digits {1,2,3,4,5,6} (digit0=6), `puntos_in`=6'b010100, `habilitar`=1.
  - Each `anodos` value 111110, 111101, …, 011111 is low for 4 cycles, preceded by 2 all-ones cycles.
  - `digito` reads 6,5,4,3,2,1 during the respective lit windows.
  - `punto`=1 only while digits 2 and 4 are lit.
  - `fin_barrido` pulses once, 36 cycles after enable.
- **Snapshot integrity:** change `digitos_in` to all 9 while digit 2 is lit. Required: the rest of the current frame still shows the old values; the next frame shows 9 on every digit.
- **Disable mid-digit:** drop `habilitar` during digit 3's lit window. Required: `anodos`=111111 on the next cycle. On re-enable, the scan restarts at digit 0 after 2 blank cycles.
- **Async reset mid-frame:** assert `rst_n`=0 between clock edges while digit 5 is lit. Required: `anodos`=111111 and `digito`=0 without waiting for a clock edge; after release, the scan restarts from INACTIVO.
- **Invariant check:** over 10 continuous frames, `anodos` never has more than one zero bit, and `fin_barrido` count = 10.
